// File: rtl/mt_sbus_xlate.sv
// mt_sbus_xlate: sequenced MBOX<->SBUS request translator (START/ACKN handshake, per-word DATA_VALID, NXM timeout)
// Optional data parity generation/checking is enabled by defining MT_SBUS_PARITY_EN.
module mt_sbus_xlate #(
    parameter int ADR_W   = 22,
    parameter int DATA_W  = 36,
    parameter int WORDS   = 4,
    parameter int TMO_CYC = 255
) (
    input  logic                       clk,
    input  logic                       CROBAR,
    input  logic                       mb_start,
    input  logic                       mb_wr,
    input  logic [WORDS-1:0]           mb_rq,
    input  logic [ADR_W-1:0]           mb_pma,
    input  logic [DATA_W-1:0]          mb_data,
    output logic                       mb_busy,
    output logic                       wr_take,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(WORDS)-1:0]   wr_idx,
    output logic [$clog2(WORDS)-1:0]   rd_idx,
    output logic                       mb_done,
    output logic                       mb_nxm,
    output logic                       mb_par_err,
    output logic                       sb_start,
    output logic                       sb_rd_rq,
    output logic                       sb_wr_rq,
    output logic [WORDS-1:0]           sb_rq,
    output logic [ADR_W-1:0]           sb_adr,
    output logic                       sb_adr_par,
    input  logic                       sb_ackn,
    input  logic                       sb_dv_in,
    output logic                       sb_dv_out,
    input  logic [DATA_W-1:0]          sb_d_in,
    output logic [DATA_W-1:0]          sb_d_out,
    input  logic                       sb_dpar_in,
    output logic                       sb_dpar_out,
    output logic                       sb_d_oe
);
    localparam int IW = $clog2(WORDS);
    typedef enum logic [2:0] {IDLE, START, ACK, XFER, DONE} state_t;
    state_t state, nxt;
    logic wr, xfer_wr, rd_acc, tmo_out, last;
    logic [WORDS-1:0] pend;
    logic [9:0] tmo;
    logic [IW-1:0] cur, j;

    // first still-pending word, searching upward from the start word with wrap
    always_comb begin
        cur = '0;
        j = '0;
        for (int k = WORDS - 1; k >= 0; k--) begin
            j = sb_adr[IW-1:0] + IW'(k);
            if (pend[j]) cur = j;
        end
    end

    assign last = pend == (WORDS'(1) << cur);

    always_comb begin
        nxt = state;
        mb_busy = state != IDLE;
        mb_done = state == DONE;
        sb_start = (state == START) || (state == ACK);
        sb_rd_rq = sb_start && !wr;
        sb_wr_rq = sb_start && wr;
        xfer_wr = (state == XFER) && wr;
        rd_acc = (state == XFER) && !wr && sb_dv_in;
        tmo_out = (tmo == 10'(TMO_CYC - 1)) &&
                  (((state == ACK) && !sb_ackn) || ((state == XFER) && !wr && !sb_dv_in));
        wr_take = xfer_wr;
        sb_dv_out = xfer_wr;
        sb_d_oe = xfer_wr;
        sb_d_out = xfer_wr ? mb_data : '0;
        wr_idx = xfer_wr ? cur : '0;
        case (state)
            IDLE:    nxt = mb_start ? (|mb_rq ? START : DONE) : IDLE;
            START:   nxt = ACK;
            ACK:     nxt = sb_ackn ? XFER : (tmo_out ? DONE : ACK);
            XFER:    nxt = (((xfer_wr || rd_acc) && last) || tmo_out) ? DONE : XFER;
            default: nxt = IDLE;
        endcase
    end

`ifdef MT_SBUS_PARITY_EN
    assign sb_dpar_out = xfer_wr ? ~^mb_data : 1'b0;
`else
    logic par_unused;
    assign par_unused = sb_dpar_in;
    assign sb_dpar_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            state <= IDLE;
            wr <= 1'b0;
            pend <= '0;
            tmo <= '0;
            sb_rq <= '0;
            sb_adr <= '0;
            sb_adr_par <= 1'b0;
            mb_nxm <= 1'b0;
            mb_par_err <= 1'b0;
            rd_valid <= 1'b0;
            rd_data <= '0;
            rd_idx <= '0;
        end else begin
            state <= nxt;
            rd_valid <= rd_acc;
            tmo <= (((state == ACK) && !sb_ackn) || ((state == XFER) && !xfer_wr && !rd_acc)) ? tmo + 10'd1 : '0;
            if ((state == IDLE) && mb_start) begin
                wr <= mb_wr;
                pend <= mb_rq;
                sb_rq <= mb_rq;
                sb_adr <= mb_pma;
                sb_adr_par <= ~^mb_pma;
                mb_nxm <= 1'b0;
                mb_par_err <= 1'b0;
            end
            if (tmo_out) mb_nxm <= 1'b1;
            if (xfer_wr || rd_acc) pend[cur] <= 1'b0;
            if (rd_acc) begin
                rd_data <= sb_d_in;
                rd_idx <= cur;
`ifdef MT_SBUS_PARITY_EN
                if (!(^{sb_d_in, sb_dpar_in})) mb_par_err <= 1'b1;
`endif
            end
        end
    end
endmodule

// File: tb/tb_mt_sbus_xlate.sv
// tb_mt_sbus_xlate: randomized MBOX requests and SBUS memory responses checked cycle by cycle against a request-level model
module tb_mt_sbus_xlate;
    localparam int AW = 22, DW = 36, NW = 4, TMO = 8;
    logic clk = 1'b0;
    logic CROBAR, mb_start, mb_wr, sb_ackn, sb_dv_in, sb_dpar_in;
    logic [NW-1:0] mb_rq, sb_rq;
    logic [AW-1:0] mb_pma, sb_adr;
    logic [DW-1:0] mb_data, rd_data, sb_d_in, sb_d_out;
    logic [1:0] wr_idx, rd_idx;
    logic mb_busy, wr_take, rd_valid, mb_done, mb_nxm, mb_par_err, sb_start, sb_rd_rq, sb_wr_rq;
    logic sb_adr_par, sb_dv_out, sb_dpar_out, sb_d_oe;

    always #5 clk = ~clk;

    mt_sbus_xlate #(.ADR_W(AW), .DATA_W(DW), .WORDS(NW), .TMO_CYC(TMO)) dut (
        .clk(clk), .CROBAR(CROBAR), .mb_start(mb_start), .mb_wr(mb_wr), .mb_rq(mb_rq),
        .mb_pma(mb_pma), .mb_data(mb_data), .mb_busy(mb_busy), .wr_take(wr_take),
        .rd_valid(rd_valid), .rd_data(rd_data), .wr_idx(wr_idx), .rd_idx(rd_idx),
        .mb_done(mb_done), .mb_nxm(mb_nxm), .mb_par_err(mb_par_err), .sb_start(sb_start),
        .sb_rd_rq(sb_rd_rq), .sb_wr_rq(sb_wr_rq), .sb_rq(sb_rq), .sb_adr(sb_adr),
        .sb_adr_par(sb_adr_par), .sb_ackn(sb_ackn), .sb_dv_in(sb_dv_in), .sb_dv_out(sb_dv_out),
        .sb_d_in(sb_d_in), .sb_d_out(sb_d_out), .sb_dpar_in(sb_dpar_in),
        .sb_dpar_out(sb_dpar_out), .sb_d_oe(sb_d_oe)
    );

    int checks = 0, failures = 0, cyc = 0, st_cyc = 0, done_cyc = -1, n_start = 0;
    int obs_ridx[$], obs_widx[$];
    logic e_busy, e_done, e_take, e_rv, e_nxm, e_par, e_start, e_rdrq, e_wrrq, e_apar, e_oe, e_dvout, e_dpar;
    logic [1:0] e_widx, e_ridx, pend_ridx;
    logic [DW-1:0] e_rdata, e_dout, pend_rdata;
    logic [NW-1:0] e_rq;
    logic [AW-1:0] e_adr;
    bit pend_rv = 0, pend_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        chk("mb_busy", 64'(mb_busy), 64'(e_busy));
        chk("mb_done", 64'(mb_done), 64'(e_done));
        chk("wr_take", 64'(wr_take), 64'(e_take));
        chk("wr_idx", 64'(wr_idx), 64'(e_widx));
        chk("rd_valid", 64'(rd_valid), 64'(e_rv));
        chk("rd_idx", 64'(rd_idx), 64'(e_ridx));
        chk("rd_data", 64'(rd_data), 64'(e_rdata));
        chk("mb_nxm", 64'(mb_nxm), 64'(e_nxm));
        chk("mb_par_err", 64'(mb_par_err), 64'(e_par));
        chk("sb_start", 64'(sb_start), 64'(e_start));
        chk("sb_rd_rq", 64'(sb_rd_rq), 64'(e_rdrq));
        chk("sb_wr_rq", 64'(sb_wr_rq), 64'(e_wrrq));
        chk("sb_rq", 64'(sb_rq), 64'(e_rq));
        chk("sb_adr", 64'(sb_adr), 64'(e_adr));
        chk("sb_adr_par", 64'(sb_adr_par), 64'(e_apar));
        chk("sb_d_oe", 64'(sb_d_oe), 64'(e_oe));
        chk("sb_d_out", 64'(sb_d_out), 64'(e_dout));
        chk("sb_dv_out", 64'(sb_dv_out), 64'(e_dvout));
        chk("sb_dpar_out", 64'(sb_dpar_out), 64'(e_dpar));
        if (rd_valid) obs_ridx.push_back(int'(rd_idx));
        if (wr_take) obs_widx.push_back(int'(wr_idx));
        if (sb_start) n_start++;
        if (mb_done) done_cyc = cyc;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // per-cycle defaults: idle inputs, random data, stray mb_start while busy; applies last cycle's read word
    task automatic dflt(input bit busy);
        mb_start = 1'b0;
        sb_ackn = 1'b0;
        sb_dv_in = 1'b0;
        sb_d_in = DW'({$urandom(), $urandom()});
        mb_data = DW'({$urandom(), $urandom()});
        sb_dpar_in = 1'($urandom());
        if (busy && $urandom_range(0, 3) == 0) begin
            mb_start = 1'b1;
            mb_wr = 1'($urandom());
            mb_rq = NW'($urandom());
            mb_pma = AW'($urandom());
        end
        e_busy = busy; e_done = 0; e_take = 0; e_widx = 0; e_start = 0; e_rdrq = 0; e_wrrq = 0;
        e_oe = 0; e_dout = '0; e_dvout = 0; e_dpar = 0;
        e_rv = pend_rv;
        if (pend_rv) begin
            e_ridx = pend_ridx;
            e_rdata = pend_rdata;
            if (pend_bad) e_par = 1'b1;
        end
        pend_rv = 0;
        pend_bad = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            dflt(0);
            sb_ackn = 1'($urandom());
            sb_dv_in = 1'($urandom());
            tick();
        end
    endtask

    // d: ACK cycles before ACKN; gmax<0 fixes every read gap to -gmax, else random 0..gmax; bad: words with bad parity
    task automatic run_req(input bit wr, input logic [3:0] rq, input logic [AW-1:0] pma, input int d,
                           input int gmax, input logic [3:0] bad, input int rst_at);
        int w[$];
        bit tmo_ev;
        int gap;
        logic [1:0] j;
        tmo_ev = 0;
        for (int k = 0; k < NW; k++) begin
            j = pma[1:0] + 2'(k);
            if (rq[j]) w.push_back(int'(j));
        end
        dflt(0);
        mb_start = 1'b1; mb_wr = wr; mb_rq = rq; mb_pma = pma;
        st_cyc = cyc;
        done_cyc = -1;
        tick();
        e_adr = pma; e_rq = rq; e_apar = ~^pma; e_nxm = 0; e_par = 0;
        if (rq == 0) begin
            dflt(1); e_done = 1; tick();
            idle(1);
            return;
        end
        dflt(1); e_start = 1; e_rdrq = !wr; e_wrrq = wr; tick();
        for (int a = 0; a < 100; a++) begin
            dflt(1); e_start = 1; e_rdrq = !wr; e_wrrq = wr;
            if (a == d) begin
                sb_ackn = 1'b1;
                tick();
                break;
            end
            tick();
            if (a == TMO - 1) begin
                tmo_ev = 1;
                break;
            end
        end
        for (int k = 0; k < w.size() && !tmo_ev; k++) begin
            if (k == rst_at) begin
                dflt(1); CROBAR = 1'b1; tick();
                CROBAR = 1'b0;
                pend_rv = 0;
                e_nxm = 0; e_par = 0; e_rq = '0; e_adr = '0; e_apar = 0; e_ridx = '0; e_rdata = '0;
                dflt(0); tick();
                return;
            end
            if (wr) begin
                dflt(1); e_oe = 1; e_take = 1; e_dvout = 1; e_widx = 2'(w[k]); e_dout = mb_data;
`ifdef MT_SBUS_PARITY_EN
                e_dpar = ~^mb_data;
`endif
                tick();
            end else begin
                gap = gmax < 0 ? -gmax : int'($urandom_range(0, gmax));
                for (int c = 0; c < 100; c++) begin
                    dflt(1);
                    if (c == gap) begin
                        sb_dv_in = 1'b1;
`ifdef MT_SBUS_PARITY_EN
                        sb_dpar_in = bad[w[k]] ^ ~^sb_d_in;
                        pend_bad = bad[w[k]];
`endif
                        pend_rv = 1; pend_ridx = 2'(w[k]); pend_rdata = sb_d_in;
                        tick();
                        break;
                    end
                    tick();
                    if (c == TMO - 1) begin
                        tmo_ev = 1;
                        break;
                    end
                end
            end
        end
        dflt(1); e_done = 1; if (tmo_ev) e_nxm = 1;
        sb_dv_in = 1'($urandom());
        tick();
        idle(1 + int'($urandom_range(0, 1)));
    endtask

    initial begin
        CROBAR = 1'b1; mb_start = 0; mb_wr = 0; mb_rq = '0; mb_pma = '0; mb_data = '0;
        sb_ackn = 0; sb_dv_in = 0; sb_d_in = '0; sb_dpar_in = 0;
        e_nxm = 0; e_par = 0; e_rq = '0; e_adr = '0; e_apar = 0; e_ridx = '0; e_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        dflt(0); tick();
        CROBAR = 1'b0;
        idle(2);

        obs_ridx.delete();
        run_req(0, 4'b1111, 22'o1002, 2, 0, 4'b0000, -1);
        chk("lit_rd_count", 64'(obs_ridx.size()), 64'd4);
        if (obs_ridx.size() == 4) begin
            chk("lit_rd_idx0", 64'(obs_ridx[0]), 64'd2);
            chk("lit_rd_idx1", 64'(obs_ridx[1]), 64'd3);
            chk("lit_rd_idx2", 64'(obs_ridx[2]), 64'd0);
            chk("lit_rd_idx3", 64'(obs_ridx[3]), 64'd1);
        end
        chk("lit_rd_nxm", 64'(mb_nxm), 64'd0);

        obs_widx.delete();
        run_req(1, 4'b0101, 22'o1000, 0, 0, 4'b0000, -1);
        chk("lit_wr_count", 64'(obs_widx.size()), 64'd2);
        if (obs_widx.size() == 2) begin
            chk("lit_wr_idx0", 64'(obs_widx[0]), 64'd0);
            chk("lit_wr_idx1", 64'(obs_widx[1]), 64'd2);
        end

        run_req(0, 4'b1111, 22'o7770, 20, 0, 4'b0000, -1);
        chk("lit_tmo_done_at", 64'(done_cyc - st_cyc), 64'd10);
        chk("lit_tmo_nxm", 64'(mb_nxm), 64'd1);
        chk("lit_tmo_sb_start", 64'(sb_start), 64'd0);

        run_req(0, 4'b1111, 22'o123, 7, 0, 4'b0000, -1);
        chk("lit_ackn_at_tmo_nxm", 64'(mb_nxm), 64'd0);

        run_req(0, 4'b0011, 22'o4441, 0, -7, 4'b0000, -1);
        chk("lit_gap7_nxm", 64'(mb_nxm), 64'd0);

        obs_ridx.delete();
        run_req(0, 4'b1111, 22'o5, 1, -8, 4'b0000, -1);
        chk("lit_gap8_nxm", 64'(mb_nxm), 64'd1);
        chk("lit_gap8_words", 64'(obs_ridx.size()), 64'd0);

        n_start = 0;
        run_req(0, 4'b0000, 22'o3333, 0, 0, 4'b0000, -1);
        chk("lit_rq0_sb_start", 64'(n_start), 64'd0);
        chk("lit_rq0_done_at", 64'(done_cyc - st_cyc), 64'd1);

        obs_ridx.delete();
        run_req(0, 4'b1111, 22'o10, 1, 1, 4'b0010, -1);
        chk("lit_par_words", 64'(obs_ridx.size()), 64'd4);
`ifdef MT_SBUS_PARITY_EN
        chk("lit_par_err", 64'(mb_par_err), 64'd1);
`else
        chk("lit_par_err", 64'(mb_par_err), 64'd0);
`endif

        run_req(0, 4'b1111, 22'o2, 1, 1, 4'b0000, 2);
        chk("lit_rst_busy", 64'(mb_busy), 64'd0);
        chk("lit_rst_adr", 64'(sb_adr), 64'd0);
        obs_ridx.delete();
        run_req(0, 4'b1001, 22'o17, 0, 0, 4'b0000, -1);
        chk("lit_after_rst_words", 64'(obs_ridx.size()), 64'd2);

        for (int i = 0; i < 150; i++) begin
            bit wr;
            wr = 1'($urandom());
            run_req(wr, 4'($urandom()), AW'($urandom()), int'($urandom_range(0, 9)),
                    int'($urandom_range(0, 9)), 4'($urandom()),
                    (!wr && $urandom_range(0, 15) == 0) ? int'($urandom_range(0, 3)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
